// File: rtl/avl_bus_arbiter_if.sv
// Avalon-style bus bundle between N masters, the arbiter and one shared slave.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface avl_bus_arbiter_if #(
  parameter int MASTER_NUM = 2
);
  logic [32*MASTER_NUM-1:0] m_address;
  logic [4*MASTER_NUM-1:0]  m_byte_en;
  logic [MASTER_NUM-1:0]    m_read;
  logic [MASTER_NUM-1:0]    m_write;
  logic [32*MASTER_NUM-1:0] m_write_data;
  logic [MASTER_NUM-1:0]    m_begin_burst_transfer;
  logic [8*MASTER_NUM-1:0]  m_burst_count;
  logic [MASTER_NUM-1:0]    m_request_ready;
  logic [32*MASTER_NUM-1:0] m_read_data;
  logic [MASTER_NUM-1:0]    m_read_data_valid;
  logic [MASTER_NUM-1:0]    m_resp_ready;

  logic [31:0] s_address;
  logic [3:0]  s_byte_en;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_write_data;
  logic        s_begin_burst_transfer;
  logic [7:0]  s_burst_count;
  logic        s_request_ready;
  logic [31:0] s_read_data;
  logic        s_read_data_valid;
  logic        s_resp_ready;

  modport slave (
    input  m_address, m_byte_en, m_read, m_write, m_write_data,
           m_begin_burst_transfer, m_burst_count, m_resp_ready,
           s_request_ready, s_read_data, s_read_data_valid,
    output m_request_ready, m_read_data, m_read_data_valid,
           s_address, s_byte_en, s_read, s_write, s_write_data,
           s_begin_burst_transfer, s_burst_count, s_resp_ready
  );

  modport master (
    output m_address, m_byte_en, m_read, m_write, m_write_data,
           m_begin_burst_transfer, m_burst_count, m_resp_ready,
           s_request_ready, s_read_data, s_read_data_valid,
    input  m_request_ready, m_read_data, m_read_data_valid,
           s_address, s_byte_en, s_read, s_write, s_write_data,
           s_begin_burst_transfer, s_burst_count, s_resp_ready
  );
endinterface

// File: rtl/avl_bus_arbiter.sv
// N-to-1 round-robin command arbiter with grant lock on stall and an in-order
// read-response router driven by a FIFO of originating master IDs.
//
// state  | meaning
// IDLE   | choose first requester from rr pointer, forward it combinationally
// LOCKED | previous command stalled; keep forwarding lock_q until accepted or dropped
module avl_bus_arbiter #(
  parameter int MASTER_NUM      = 2,
  parameter int OUTSTANDING_MAX = 4,
  parameter int IDW             = $clog2(MASTER_NUM)
) (
  input  logic              clk,
  input  logic              rest,
  avl_bus_arbiter_if.slave  bus
);

  localparam int AW = $clog2(OUTSTANDING_MAX);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        lock_q, lock_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic [IDW-1:0]        winner, cand, gnt_id, head;
  logic [MASTER_NUM-1:0] req;
  logic                  gnt_valid, is_read, blocked, accept, push, pop;
  logic                  fifo_empty, fifo_full, resp_ready;

  logic [IDW-1:0]        id_mem [OUTSTANDING_MAX];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (i == IDW'(MASTER_NUM - 1)) return '0;
    return i + 1'b1;
  endfunction

  assign req = bus.m_read | bus.m_write;

  // Scan downwards so the requester closest to rr_q is the last one written.
  always_comb begin
    winner = rr_q;
    cand   = '0;
    for (int k = MASTER_NUM - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_q) + k) % MASTER_NUM);
      if (req[cand]) winner = cand;
    end
  end

  assign gnt_id    = (state_q == LOCKED) ? lock_q : winner;
  assign gnt_valid = (state_q == LOCKED) ? req[lock_q] : (|req);
  assign is_read   = bus.m_read[gnt_id];
  assign blocked   = is_read & fifo_full & ~pop;
  assign accept    = gnt_valid & ~blocked & bus.s_request_ready;
  assign push      = accept & is_read;

  always_comb begin
    bus.s_address              = '0;
    bus.s_byte_en              = '0;
    bus.s_read                 = 1'b0;
    bus.s_write                = 1'b0;
    bus.s_write_data           = '0;
    bus.s_begin_burst_transfer = 1'b0;
    bus.s_burst_count          = '0;
    bus.m_request_ready        = '0;
    if (gnt_valid) begin
      bus.s_address              = bus.m_address[int'(gnt_id)*32 +: 32];
      bus.s_byte_en              = bus.m_byte_en[int'(gnt_id)*4 +: 4];
      bus.s_write_data           = bus.m_write_data[int'(gnt_id)*32 +: 32];
      bus.s_begin_burst_transfer = bus.m_begin_burst_transfer[gnt_id];
      bus.s_burst_count          = bus.m_burst_count[int'(gnt_id)*8 +: 8];
      bus.s_read                 = is_read & ~blocked;
      bus.s_write                = ~is_read;
      bus.m_request_ready[gnt_id] = accept;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          if (accept) begin
            rr_d = next_idx(winner);
          end else begin
            state_d = LOCKED;
            lock_d  = winner;
          end
        end
      end
      LOCKED: begin
        if (!req[lock_q]) begin
          state_d = IDLE;
        end else if (accept) begin
          rr_d    = next_idx(lock_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
    end
  end

  // Response routing: the FIFO head names the master owed the next beat.
  assign head       = id_mem[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(OUTSTANDING_MAX));

  always_comb begin
    bus.m_read_data_valid = '0;
    resp_ready            = 1'b1;
    if (!fifo_empty) begin
      bus.m_read_data_valid[head] = bus.s_read_data_valid;
      resp_ready                  = bus.m_resp_ready[head];
    end
  end

  assign bus.s_resp_ready = resp_ready;
  assign bus.m_read_data  = {MASTER_NUM{bus.s_read_data}};
  assign pop              = ~fifo_empty & bus.s_read_data_valid & resp_ready;

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_q] <= gnt_id;
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// Directed bench for avl_bus_arbiter: two masters, four outstanding reads.
module tb_avl_bus_arbiter;
  localparam int MN = 2;
  localparam int OM = 4;

  logic clk  = 1'b0;
  logic rest = 1'b1;
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  avl_bus_arbiter_if #(.MASTER_NUM(MN)) bus();

  avl_bus_arbiter #(.MASTER_NUM(MN), .OUTSTANDING_MAX(OM)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int i, input logic rd, input logic wr, input logic [31:0] addr);
    bus.m_read[i]                 = rd;
    bus.m_write[i]                = wr;
    bus.m_address[i*32 +: 32]     = addr;
    bus.m_write_data[i*32 +: 32]  = addr ^ 32'h5A5A_0000;
    bus.m_byte_en[i*4 +: 4]       = 4'hF;
    bus.m_burst_count[i*8 +: 8]   = 8'd1;
    bus.m_begin_burst_transfer[i] = 1'b0;
  endtask

  initial begin
    bus.m_address              = '0;
    bus.m_byte_en              = '0;
    bus.m_read                 = '0;
    bus.m_write                = '0;
    bus.m_write_data           = '0;
    bus.m_begin_burst_transfer = '0;
    bus.m_burst_count          = '0;
    bus.m_resp_ready           = 2'b11;
    bus.s_request_ready        = 1'b0;
    bus.s_read_data            = '0;
    bus.s_read_data_valid      = 1'b0;

    // reset state
    #1 rest = 1'b0;
    settle();
    chk("rst_s_read",      32'(bus.s_read),            32'h0);
    chk("rst_s_write",     32'(bus.s_write),           32'h0);
    chk("rst_s_address",   32'(bus.s_address),         32'h0);
    chk("rst_m_req_ready", 32'(bus.m_request_ready),   32'h0);
    chk("rst_m_rdv",       32'(bus.m_read_data_valid), 32'h0);
    chk("rst_s_resp_rdy",  32'(bus.s_resp_ready),      32'h1);
    tick();
    tick();
    rest = 1'b1;

    // single read from master 1
    drive(1, 1'b1, 1'b0, 32'h100);
    bus.s_request_ready = 1'b1;
    settle();
    chk("t1_s_address",   32'(bus.s_address),       32'h100);
    chk("t1_s_read",      32'(bus.s_read),          32'h1);
    chk("t1_m_req_ready", 32'(bus.m_request_ready), 32'h2);
    tick();
    drive(1, 1'b0, 1'b0, 32'h0);
    bus.s_request_ready   = 1'b0;
    bus.s_read_data_valid = 1'b1;
    bus.s_read_data       = 32'hDEAD_BEEF;
    settle();
    chk("t1_m_rdv",       32'(bus.m_read_data_valid), 32'h2);
    chk("t1_m1_data",     bus.m_read_data[63:32],     32'hDEAD_BEEF);
    chk("t1_s_resp_rdy",  32'(bus.s_resp_ready),      32'h1);
    tick();
    bus.s_read_data_valid = 1'b0;

    // continuous writes from both masters alternate
    drive(0, 1'b0, 1'b1, 32'hA0);
    drive(1, 1'b0, 1'b1, 32'hB0);
    bus.s_request_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t2_grant%0d", k), 32'(bus.m_request_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("t2_addr%0d", k),  bus.s_address,            (k % 2 == 0) ? 32'hA0 : 32'hB0);
      chk($sformatf("t2_write%0d", k), 32'(bus.s_write),         32'h1);
      tick();
    end
    drive(0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0);
    bus.s_request_ready   = 1'b0;
    bus.s_read_data_valid = 1'b1;
    settle();
    chk("t2_no_push_rdv", 32'(bus.m_read_data_valid), 32'h0);
    chk("t2_no_push_rdy", 32'(bus.s_resp_ready),      32'h1);
    tick();
    bus.s_read_data_valid = 1'b0;

    // stalled read holds the grant while master 1 waits
    drive(0, 1'b1, 1'b0, 32'h200);
    drive(1, 1'b0, 1'b1, 32'h300);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("t3_hold_addr%0d", k), bus.s_address,            32'h200);
      chk($sformatf("t3_hold_rdy%0d", k),  32'(bus.m_request_ready), 32'h0);
      tick();
    end
    bus.s_request_ready = 1'b1;
    settle();
    chk("t3_accept_m0", 32'(bus.m_request_ready), 32'h1);
    chk("t3_accept_rd", 32'(bus.s_read),          32'h1);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("t3_next_m1",   32'(bus.m_request_ready), 32'h2);
    chk("t3_next_addr", bus.s_address,            32'h300);
    tick();
    drive(1, 1'b0, 1'b0, 32'h0);
    bus.s_request_ready   = 1'b0;
    bus.s_read_data_valid = 1'b1;
    bus.s_read_data       = 32'h55;
    settle();
    chk("t3_resp_m0", 32'(bus.m_read_data_valid), 32'h1);
    tick();
    bus.s_read_data_valid = 1'b0;

    // fill the ID FIFO, then block a fifth read until a pop
    drive(0, 1'b1, 1'b0, 32'h400);
    bus.s_request_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t4_fill%0d", k), 32'(bus.m_request_ready), 32'h1);
      tick();
    end
    settle();
    chk("t4_blk_s_read", 32'(bus.s_read),          32'h0);
    chk("t4_blk_rdy",    32'(bus.m_request_ready), 32'h0);
    tick();
    settle();
    chk("t4_blk2_s_read", 32'(bus.s_read), 32'h0);
    tick();
    bus.s_read_data_valid = 1'b1;
    bus.s_read_data       = 32'h66;
    settle();
    chk("t4_pop_s_read", 32'(bus.s_read),            32'h1);
    chk("t4_pop_rdy",    32'(bus.m_request_ready),   32'h1);
    chk("t4_pop_rdv",    32'(bus.m_read_data_valid), 32'h1);
    tick();
    bus.s_read_data_valid = 1'b0;
    settle();
    chk("t4_still_full", 32'(bus.s_read), 32'h0);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0);
    bus.s_request_ready   = 1'b0;
    bus.s_read_data_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("t4_drain%0d", k), 32'(bus.m_read_data_valid), 32'h1);
      tick();
    end
    settle();
    chk("t4_empty_rdv", 32'(bus.m_read_data_valid), 32'h0);
    chk("t4_empty_rdy", 32'(bus.s_resp_ready),      32'h1);
    tick();
    bus.s_read_data_valid = 1'b0;

    // interleaved reads M0, M1, M0 with backpressure from M1
    bus.s_request_ready = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h10);
    settle();
    chk("t5_cmd0", 32'(bus.m_request_ready), 32'h1);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h14);
    settle();
    chk("t5_cmd1", 32'(bus.m_request_ready), 32'h2);
    tick();
    drive(1, 1'b0, 1'b0, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h18);
    settle();
    chk("t5_cmd2", 32'(bus.m_request_ready), 32'h1);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0);
    bus.s_request_ready   = 1'b0;
    bus.m_resp_ready      = 2'b01;
    bus.s_read_data_valid = 1'b1;
    bus.s_read_data       = 32'h11;
    settle();
    chk("t5_r0_rdv",  32'(bus.m_read_data_valid), 32'h1);
    chk("t5_r0_data", bus.m_read_data[31:0],      32'h11);
    chk("t5_r0_rdy",  32'(bus.s_resp_ready),      32'h1);
    tick();
    bus.s_read_data = 32'h22;
    settle();
    chk("t5_bp0_rdy", 32'(bus.s_resp_ready),      32'h0);
    chk("t5_bp0_rdv", 32'(bus.m_read_data_valid), 32'h2);
    tick();
    settle();
    chk("t5_bp1_rdy", 32'(bus.s_resp_ready), 32'h0);
    tick();
    bus.m_resp_ready = 2'b11;
    settle();
    chk("t5_r1_rdy",  32'(bus.s_resp_ready),      32'h1);
    chk("t5_r1_rdv",  32'(bus.m_read_data_valid), 32'h2);
    chk("t5_r1_data", bus.m_read_data[63:32],     32'h22);
    tick();
    bus.s_read_data = 32'h33;
    settle();
    chk("t5_r2_rdv",  32'(bus.m_read_data_valid), 32'h1);
    chk("t5_r2_data", bus.m_read_data[31:0],      32'h33);
    tick();
    bus.s_read_data_valid = 1'b0;

    // reset with two reads outstanding
    bus.s_request_ready = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h20);
    tick();
    tick();
    drive(0, 1'b0, 1'b0, 32'h0);
    bus.s_request_ready = 1'b0;
    bus.m_resp_ready    = 2'b00;
    settle();
    chk("t6_pending_rdy", 32'(bus.s_resp_ready), 32'h0);
    bus.m_resp_ready = 2'b11;
    rest = 1'b0;
    settle();
    chk("t6_in_reset_rdy", 32'(bus.s_resp_ready), 32'h1);
    tick();
    rest = 1'b1;
    bus.s_read_data_valid = 1'b1;
    bus.s_read_data       = 32'h77;
    settle();
    chk("t6_drop_rdv", 32'(bus.m_read_data_valid), 32'h0);
    chk("t6_drop_rdy", 32'(bus.s_resp_ready),      32'h1);
    tick();
    bus.s_read_data_valid = 1'b0;
    drive(0, 1'b0, 1'b1, 32'hC0);
    drive(1, 1'b0, 1'b1, 32'hD0);
    bus.s_request_ready = 1'b1;
    settle();
    chk("t6_rr_reset", 32'(bus.m_request_ready), 32'h1);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0);
    bus.s_request_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/avl_bus_arbiter.md
Name: avl_bus_arbiter

Overview:
- N-master to 1-slave arbiter for the avl bus. It shares a single slave port (memory controller or peripheral crossbar) between several requesters: CPU I-port, D-port and DMA.
- Round-robin command arbitration with a grant lock while a command is stalled.
- Read responses are returned in order to the originating master via an internal master-ID FIFO.

Parameters:
- MASTER_NUM, 2, number of requesting masters (2..8).
- OUTSTANDING_MAX, 4, depth of the read-ID FIFO (power of 2); maximum reads in flight.
- IDW, $clog2(MASTER_NUM), derived width of a master index.

Ports:
- clk  in  1  system clock
- rest  in  1  asynchronous reset, active low
- m_address  in  32*MASTER_NUM  per-master word address (slice i = master i)
- m_byte_en  in  4*MASTER_NUM  per-master byte enables
- m_read  in  MASTER_NUM  per-master read request
- m_write  in  MASTER_NUM  per-master write request
- m_write_data  in  32*MASTER_NUM  per-master write data
- m_begin_burst_transfer  in  MASTER_NUM  forwarded unchanged with the granted command
- m_burst_count  in  8*MASTER_NUM  forwarded unchanged with the granted command
- m_request_ready  out  MASTER_NUM  command accepted (one-hot or zero)
- m_read_data  out  32*MASTER_NUM  slave read_data broadcast to all slices
- m_read_data_valid  out  MASTER_NUM  response valid, routed to FIFO-head master only
- m_resp_ready  in  MASTER_NUM  per-master response ready
- s_address, s_byte_en, s_read, s_write, s_write_data, s_begin_burst_transfer, s_burst_count  out  32/4/1/1/32/1/8  slave command
- s_request_ready  in  1  slave accepts command
- s_read_data  in  32  slave read data
- s_read_data_valid  in  1  slave response valid
- s_resp_ready  out  1  arbiter accepts response

Behaviour:
- Reset (rest low, async):
  - grant state = IDLE, rr pointer = 0, FIFO empty.
  - All s_* command outputs 0; m_request_ready = 0; m_read_data_valid = 0.
  - s_resp_ready = 1.
- Master i is requesting when m_read[i] or m_write[i] is high. A master asserting both is treated as a read.
- Grant FSM:
  - IDLE: pick the first requesting master starting at rr pointer, wrapping modulo MASTER_NUM, and forward its command combinationally to s_* in the same cycle.
  - On s_request_ready that cycle, the command is accepted, rr pointer becomes winner+1 (mod MASTER_NUM), and the FSM stays IDLE.
  - If not accepted, go to LOCKED(winner).
  - LOCKED(g): forward master g only. On acceptance, rr pointer = g+1 and return to IDLE. If master g drops its request, return to IDLE without accepting and leave the rr pointer unchanged.
- Command stall on full FIFO: a read is forwarded only if the FIFO is not full, or a pop occurs in the same cycle. Otherwise s_read = 0 and m_request_ready = 0; the grant stays locked. Writes are never blocked by FIFO state.
- m_request_ready[i] = s_request_ready AND (i is granted) AND (command not blocked). Zero latency.
- Read acceptance (s_read & s_request_ready) pushes the winner index into the FIFO, registered at the clock edge.
- Response path:
  - FIFO non-empty with head h: m_read_data_valid[h] = s_read_data_valid and s_resp_ready = m_resp_ready[h].
  - Pop on s_read_data_valid & s_resp_ready. Push and pop in the same cycle leave the count unchanged; this is legal when full.
  - FIFO empty: s_resp_ready = 1 and any stray s_read_data_valid is dropped (m_read_data_valid all 0).
- Writes produce no response and no FIFO entry.
- Every accepted read produces exactly one response beat; burst fields are pass-through only.
- Counters and pointers wrap modulo OUTSTANDING_MAX. The count field is $clog2(OUTSTANDING_MAX)+1 bits.
- Reset mid-operation discards all outstanding IDs; the slave's late responses are drained per the empty rule.

Test Plan:
- Single master 1 reads addr 0x100, slave ready -> s_address = 0x100 and m_request_ready = 2'b10 in the same cycle; FIFO holds 1; response 0xDEADBEEF is seen only on m_read_data_valid[1].
- Masters 0 and 1 issue continuous writes, slave always ready -> grants alternate 0,1,0,1 over 4 cycles; no FIFO pushes.
- Master 0 read, slave holds s_request_ready = 0 for 3 cycles while master 1 also requests -> s_address stays on master 0 for all 3 cycles; master 1 is granted the cycle after acceptance.
- OUTSTANDING_MAX = 4, 4 reads accepted with no responses -> 5th read gets s_read = 0 and m_request_ready = 0. The cycle a response pops, the 5th read is accepted; count stays 4.
- Interleaved reads M0, M1, M0 with responses 0x11, 0x22, 0x33 and m_resp_ready[1] low for 2 cycles -> s_resp_ready is low during that window; data is delivered to M0, M1, M0 in order.
- Assert rest low with 2 reads outstanding, release, then slave returns 1 response -> it is dropped, s_resp_ready = 1, all m_read_data_valid = 0.
